// File: rtl/div_rem_unit.sv
// Sequential restoring divider, one quotient bit per clock.
// Splits a double-width dividend into quotient and remainder.
module div_rem_unit #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [OUT_WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Partial remainder is one bit wider so the shifted value never wraps.
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] hi_half;
    logic [WIDTH-1:0] lo_half;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_sub;
    logic [WIDTH:0]   p_next;
    logic             qbit;
    logic [WIDTH-1:0] q_next;

    assign hi_half = dividend[OUT_WIDTH-1:WIDTH];
    assign lo_half = dividend[WIDTH-1:0];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        p_shift = {p_q[WIDTH-1:0], s_q[WIDTH-1]};
        p_sub   = p_shift - {1'b0, b_q};
        qbit    = (p_shift >= {1'b0, b_q});
        p_next  = qbit ? p_sub : p_shift;
        q_next  = {qw_q[WIDTH-2:0], qbit};
    end

    // Next-state and datapath control for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        s_d         = s_q;
        b_d         = b_q;
        qw_d        = qw_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d   = divisor;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = lo_half;
                        state_d     = S_DONE;
                    end else if (hi_half >= divisor) begin
                        ovf_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        p_d     = {1'b0, hi_half};
                        s_d     = lo_half;
                        qw_d    = '0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                p_d   = p_next;
                s_d   = {s_q[WIDTH-2:0], 1'b0};
                qw_d  = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quotient_d  = q_next;
                    remainder_d = p_next[WIDTH-1:0];
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            s_q         <= '0;
            b_q         <= '0;
            qw_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            s_q         <= s_d;
            b_q         <= b_d;
            qw_q        <= qw_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed testbench for div_rem_unit.
// Hand-computed vectors checked with immediate assertions.
module tb_div_rem_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    div_rem_unit #(.WIDTH(8), .OUT_WIDTH(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] r,
                          input logic [7:0] b, input logic [7:0] q,
                          input logic [7:0] c, input logic dz,
                          input logic ov, input int lat);
        int waited;
        int busy_n;
        @(negedge clk);
        dividend = r;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        waited = 0;
        busy_n = 0;
        while (!done && waited < 40) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            waited++;
        end
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_lat"}, 16'(waited), 16'(lat));
        chk({tag, "_busy"}, 16'(busy_n), 16'(lat));
        chk({tag, "_q"}, 16'(quotient), 16'(q));
        chk({tag, "_c"}, 16'(remainder), 16'(c));
        chk({tag, "_dz"}, 16'(div_by_zero), 16'(dz));
        chk({tag, "_ov"}, 16'(overflow), 16'(ov));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 16'(done), 16'd0);
        chk({tag, "_hold"}, 16'(quotient), 16'(q));
    endtask

    initial begin
        int waited;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_q", 16'(quotient), 16'd0);
        chk("rst_c", 16'(remainder), 16'd0);
        chk("rst_dz", 16'(div_by_zero), 16'd0);
        chk("rst_ov", 16'(overflow), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("t1", 16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);
        run_op("t2a", 16'd148, 8'd11, 8'd13, 8'd5, 1'b0, 1'b0, 8);
        run_op("t2b", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8);
        run_op("t3", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 0);
        run_op("t4a", 16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
        run_op("t4b", 16'h0700, 8'h07, 8'hFF, 8'h00, 1'b0, 1'b1, 0);

        // start held high: a new request is taken right after each done
        @(negedge clk);
        dividend = 16'h1234;
        divisor  = 8'h00;
        start    = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_d1", 16'(done), 16'd1);
        @(posedge clk);
        #1;
        chk("hold_idle", 16'(done), 16'd0);
        @(posedge clk);
        #1;
        chk("hold_d2", 16'(done), 16'd1);
        chk("hold_dz", 16'(div_by_zero), 16'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("hold_stop", 16'(done), 16'd0);

        // start during RUN is ignored
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = 16'd5;
        divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!done && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("t5_done", 16'(done), 16'd1);
        chk("t5_q", 16'(quotient), 16'd111);
        chk("t5_c", 16'(remainder), 16'd1);
        chk("t5_flags", {14'd0, div_by_zero, overflow}, 16'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t5_nobusy", 16'(busy), 16'd0);
        chk("t5_nodone", 16'(done), 16'd0);

        // reset in the middle of an operation
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_run", 16'(busy), 16'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 16'(busy), 16'd0);
        chk("t6_done", 16'(done), 16'd0);
        chk("t6_q", 16'(quotient), 16'd0);
        chk("t6_c", 16'(remainder), 16'd0);
        chk("t6_flags", {14'd0, div_by_zero, overflow}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_nodone", 16'(done), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_idle", 16'(done | busy), 16'd0);
        run_op("t6r", 16'd148, 8'd11, 8'd13, 8'd5, 1'b0, 1'b0, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
